// File: rtl/alu_if.sv
// Operand, control and registered result/flag bundle for the ALU.
// The master drives operands and the op select; the slave returns the result and flags.
interface alu_if #(
    parameter int WIDTH = 32
);
    logic [WIDTH-1:0] SrcA;
    logic [WIDTH-1:0] SrcB;
    logic [3:0]       ALUControl;
    logic [WIDTH-1:0] ALUResult;
    logic             Zero;
    logic             Negative;
    logic             Carry;
    logic             Overflow;

    modport master (
        output SrcA, SrcB, ALUControl,
        input  ALUResult, Zero, Negative, Carry, Overflow
    );

    modport slave (
        input  SrcA, SrcB, ALUControl,
        output ALUResult, Zero, Negative, Carry, Overflow
    );
endinterface

// File: rtl/alu.sv
// Single-cycle-latency ALU: result and flags are computed combinationally
// from the current operands and registered on every rising clock edge.
module alu #(
    parameter int WIDTH = 32
) (
    input  logic  clk,
    input  logic  rst_n,
    alu_if.slave  bus
);
    localparam int MSB = WIDTH - 1;

    typedef enum logic [3:0] {
        OP_ADD  = 4'b0000,
        OP_SUB  = 4'b0001,
        OP_AND  = 4'b0010,
        OP_OR   = 4'b0011,
        OP_SLT  = 4'b0101,
        OP_XOR  = 4'b0111,
        OP_SRA  = 4'b1000,
        OP_SRL  = 4'b1001,
        OP_SLL  = 4'b1010,
        OP_SLTU = 4'b1011
    } op_e;

    op_e              op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [4:0]       shamt;
    logic [WIDTH:0]   sum_ext;
    logic [WIDTH:0]   diff_ext;
    logic             slt;
    logic             sltu;

    logic [WIDTH-1:0] res_d;
    logic             carry_d;
    logic             ovf_d;

    assign op    = op_e'(bus.ALUControl);
    assign a     = bus.SrcA;
    assign b     = bus.SrcB;
    assign shamt = b[4:0];

    // Subtraction as A + ~B + 1 so the top bit is the "no borrow" carry.
    assign sum_ext  = {1'b0, a} + {1'b0, b};
    assign diff_ext = {1'b0, a} + {1'b0, ~b} + (WIDTH + 1)'(1);

    // Mixed signs decide SLT directly; otherwise the difference cannot overflow.
    assign slt  = (a[MSB] ^ b[MSB]) ? a[MSB] : diff_ext[MSB];
    assign sltu = ~diff_ext[WIDTH];

    always_comb begin
        res_d   = '0;
        carry_d = 1'b0;
        ovf_d   = 1'b0;
        case (op)
            OP_ADD: begin
                res_d   = sum_ext[MSB:0];
                carry_d = sum_ext[WIDTH];
                ovf_d   = (a[MSB] == b[MSB]) && (sum_ext[MSB] != a[MSB]);
            end
            OP_SUB: begin
                res_d   = diff_ext[MSB:0];
                carry_d = diff_ext[WIDTH];
                ovf_d   = (a[MSB] != b[MSB]) && (diff_ext[MSB] != a[MSB]);
            end
            OP_AND:  res_d = a & b;
            OP_OR:   res_d = a | b;
            OP_XOR:  res_d = a ^ b;
            OP_SLT:  res_d = {{(WIDTH - 1){1'b0}}, slt};
            OP_SLTU: res_d = {{(WIDTH - 1){1'b0}}, sltu};
            OP_SRA:  res_d = $unsigned($signed(a) >>> shamt);
            OP_SRL:  res_d = a >> shamt;
            OP_SLL:  res_d = a << shamt;
            default: res_d = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.ALUResult <= '0;
            bus.Zero      <= 1'b1;
            bus.Negative  <= 1'b0;
            bus.Carry     <= 1'b0;
            bus.Overflow  <= 1'b0;
        end else begin
            bus.ALUResult <= res_d;
            bus.Zero      <= (res_d == '0);
            bus.Negative  <= res_d[MSB];
            bus.Carry     <= carry_d;
            bus.Overflow  <= ovf_d;
        end
    end
endmodule

// File: tb/tb_alu.sv
// Scoreboard bench for alu: stimulus pushes hand-computed expectations,
// a monitor pops and compares one registered result per issued operation.
module tb_alu;
    localparam logic [3:0] ADD  = 4'b0000, SUB = 4'b0001, AND_ = 4'b0010, OR_ = 4'b0011,
                           SLT  = 4'b0101, XOR_ = 4'b0111, SRA = 4'b1000, SRL = 4'b1001,
                           SLL  = 4'b1010, SLTU = 4'b1011;

    typedef struct {
        string       name;
        logic [31:0] res;
        logic        z, n, c, v;
    } exp_t;

    logic clk;
    logic rst_n;
    logic in_valid;
    exp_t q[$];
    int   errors;
    int   checks;

    alu_if #(.WIDTH(32)) bus ();

    alu #(.WIDTH(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic issue(input string name, input logic [3:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] res,
                         input logic z, input logic n, input logic c, input logic v);
        exp_t e;
        @(negedge clk);
        bus.ALUControl = op;
        bus.SrcA       = a;
        bus.SrcB       = b;
        in_valid       = 1'b1;
        e.name = name; e.res = res; e.z = z; e.n = n; e.c = c; e.v = v;
        q.push_back(e);
    endtask

    task automatic idle();
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic check_now(input string name, input logic [31:0] res,
                             input logic z, input logic n, input logic c, input logic v);
        checks++;
        if (bus.ALUResult !== res || bus.Zero !== z || bus.Negative !== n ||
            bus.Carry !== c || bus.Overflow !== v) begin
            errors++;
            $display("FAIL %s: got res=%h z=%b n=%b c=%b v=%b, want res=%h z=%b n=%b c=%b v=%b",
                     name, bus.ALUResult, bus.Zero, bus.Negative, bus.Carry, bus.Overflow,
                     res, z, n, c, v);
        end
    endtask

    // Monitor: an operation presented before an edge is visible just after it.
    initial begin
        logic v;
        exp_t e;
        forever begin
            @(posedge clk);
            v = in_valid;
            #1;
            if (v) begin
                if (q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL scoreboard_underflow: got result with no expectation, want none");
                end else begin
                    e = q.pop_front();
                    check_now(e.name, e.res, e.z, e.n, e.c, e.v);
                end
            end
        end
    end

    initial begin
        errors         = 0;
        checks         = 0;
        in_valid       = 1'b0;
        rst_n          = 1'b0;
        bus.ALUControl = ADD;
        bus.SrcA       = 32'd5;
        bus.SrcB       = 32'd3;

        // Held in reset with nonzero inputs while the clock runs.
        repeat (2) @(posedge clk);
        #2 check_now("reset_hold", 32'h0, 1'b1, 1'b0, 1'b0, 1'b0);

        // First edge after release registers the current inputs.
        @(negedge clk);
        rst_n = 1'b1;
        issue("add_5_3",      ADD,  32'd5,        32'd3,        32'h8,        0, 0, 0, 0);
        issue("sub_5_3",      SUB,  32'd5,        32'd3,        32'h2,        0, 0, 1, 0);
        issue("sub_5_5",      SUB,  32'd5,        32'd5,        32'h0,        1, 0, 1, 0);
        issue("sub_3_5",      SUB,  32'd3,        32'd5,        32'hFFFFFFFE, 0, 1, 0, 0);
        issue("and_f_3",      AND_, 32'hF,        32'h3,        32'h3,        0, 0, 0, 0);
        issue("and_ones",     AND_, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 0, 1, 0, 0);
        issue("or_c_3",       OR_,  32'hC,        32'h3,        32'hF,        0, 0, 0, 0);
        issue("xor_f_3",      XOR_, 32'hF,        32'h3,        32'hC,        0, 0, 0, 0);
        issue("sll_1_4",      SLL,  32'h1,        32'd4,        32'h10,       0, 0, 0, 0);
        issue("srl_10_2",     SRL,  32'h10,       32'd2,        32'h4,        0, 0, 0, 0);
        issue("sra_neg_4",    SRA,  32'h80000000, 32'd4,        32'hF8000000, 0, 1, 0, 0);
        issue("srl_neg_4",    SRL,  32'h80000000, 32'd4,        32'h08000000, 0, 0, 0, 0);
        issue("sll_b24",      SLL,  32'h1,        32'h24,       32'h10,       0, 0, 0, 0);
        issue("sll_by0",      SLL,  32'hA5,       32'h0,        32'hA5,       0, 0, 0, 0);
        issue("slt_2_5",      SLT,  32'd2,        32'd5,        32'h1,        0, 0, 0, 0);
        issue("slt_neg_neg",  SLT,  32'hF0000000, 32'hF000000F, 32'h1,        0, 0, 0, 0);
        issue("slt_pos_neg",  SLT,  32'h000F00B0, 32'hF000000F, 32'h0,        1, 0, 0, 0);
        issue("sltu_small",   SLTU, 32'h000F00B0, 32'hF000000F, 32'h1,        0, 0, 0, 0);
        issue("slt_ovf",      SLT,  32'h7FFFFFFF, 32'h80000000, 32'h0,        1, 0, 0, 0);
        issue("add_ovf",      ADD,  32'h7FFFFFFF, 32'h1,        32'h80000000, 0, 1, 0, 1);
        issue("add_carry",    ADD,  32'hFFFFFFFF, 32'h1,        32'h0,        1, 0, 1, 0);
        issue("sub_ovf",      SUB,  32'h80000000, 32'h1,        32'h7FFFFFFF, 0, 0, 1, 1);
        issue("unused_0100",  4'b0100, 32'd5,     32'd3,        32'h0,        1, 0, 0, 0);
        issue("unused_0110",  4'b0110, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0,     1, 0, 0, 0);
        issue("unused_1111",  4'b1111, 32'hFFFFFFFF, 32'h1,     32'h0,        1, 0, 0, 0);

        // Inputs changed between edges must not reach the outputs.
        issue("add_10_20",    ADD,  32'h10,       32'h20,       32'h30,       0, 0, 0, 0);
        @(posedge clk);
        #2 bus.SrcA = 32'h100;
        #1 check_now("hold_between_edges", 32'h30, 1'b0, 1'b0, 1'b0, 1'b0);
        issue("add_after_hold", ADD, 32'h100,     32'h20,       32'h120,      0, 0, 0, 0);

        // Mid-cycle asynchronous reset with a nonzero result registered.
        issue("or_before_rst", OR_, 32'hC,        32'h3,        32'hF,        0, 0, 0, 0);
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1 check_now("async_reset", 32'h0, 1'b1, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        in_valid       = 1'b0;
        bus.ALUControl = ADD;
        bus.SrcA       = 32'd1;
        bus.SrcB       = 32'd1;
        @(posedge clk);
        #2 check_now("reset_discard", 32'h0, 1'b1, 1'b0, 1'b0, 1'b0);
        issue("add_after_rst", ADD, 32'd2,        32'd2,        32'h4,        0, 0, 0, 0);
        rst_n = 1'b1;
        idle();

        repeat (3) @(posedge clk);
        #2;
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d pending, want 0", q.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL timeout: got no finish by 20000, want finish");
        $fatal(1, "timeout");
    end
endmodule
